// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : bcd_pkg                                                   |
// | Purpose  : Shared types and constants for the digit-serial BCD       |
// |            add/sub datapath: controller state encoding, digit width, |
// |            BCD constants and a 9's complement helper.                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // 9's complement of one BCD digit; non-BCD inputs simply wrap.
  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
    return BCD_NINE - d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : add_sub                                                   |
// | Purpose  : Single-digit BCD add/subtract cell. With m=1 operand b is |
// |            replaced by its 9's complement, so a 10's complement      |
// |            subtract is obtained by also setting cin=1.               |
// | Ports    : a, b  - BCD digit operands                                |
// |            cin   - decimal carry in                                  |
// |            m     - 0 = add, 1 = complement b                         |
// |            f     - BCD sum digit                                     |
// |            cout  - decimal carry out                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module add_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  input  logic               m,
  output logic [DIGIT_W-1:0] f,
  output logic               cout
);

  logic [DIGIT_W-1:0] w_b_eff;
  logic [DIGIT_W:0]   w_sum;
  logic [DIGIT_W:0]   w_sum_adj;

  assign w_b_eff   = m ? nines_comp(b) : b;
  assign w_sum     = {1'b0, a} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, cin};
  // Subtracting ten is the same as the classic +6 correction modulo 16.
  assign w_sum_adj = w_sum - 5'd10;
  assign cout      = (w_sum > 5'd9);
  assign f         = cout ? w_sum_adj[DIGIT_W-1:0] : w_sum[DIGIT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/bcd_serial_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_serial_addsub                                         |
// | Purpose  : Digit-serial NDIG-digit BCD adder/subtractor. Operands    |
// |            are latched on start and fed LSD first through a single   |
// |            add_sub cell, one digit per clock. A negative difference  |
// |            is recomplemented in a second pass to give sign-magnitude.|
// | Ports    : clk, rst     - clock, synchronous active-high reset       |
// |            start, op_m  - request (when ready) and 0=add / 1=sub     |
// |            a_in, b_in   - packed BCD operands, digit 0 in [3:0]      |
// |            ready, busy  - IDLE / CALC-or-FIX status                  |
// |            done         - one-cycle result-valid pulse               |
// |            result, sign - packed BCD magnitude and negative flag     |
// |            overflow     - final decimal carry of an add              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    op_m,
  input  logic [NDIG*DIGIT_W-1:0] a_in,
  input  logic [NDIG*DIGIT_W-1:0] b_in,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [NDIG*DIGIT_W-1:0] result,
  output logic                    sign,
  output logic                    overflow
);

  localparam int W     = NDIG * DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NDIG - 1);
  localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);

  state_t             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_m;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [W-1:0]       r_result;
  logic               r_sign;
  logic               r_overflow;
  logic               r_done;
  logic               r_ready;
  logic               r_busy;

  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic [DIGIT_W-1:0] w_res_dig;
  logic [DIGIT_W-1:0] w_cell_a;
  logic [DIGIT_W-1:0] w_cell_b;
  logic               w_cell_m;
  logic               w_is_fix;
  logic [DIGIT_W-1:0] w_f;
  logic               w_cout;

  assign w_a_dig   = r_a[r_idx*DIGIT_W +: DIGIT_W];
  assign w_b_dig   = r_b[r_idx*DIGIT_W +: DIGIT_W];
  assign w_res_dig = r_result[r_idx*DIGIT_W +: DIGIT_W];

  // The recomplement pass computes 0 - result (10's complement) digit by
  // digit, reusing the same cell with the latched operands swapped out.
  assign w_is_fix  = (r_state == FIX);
  assign w_cell_a  = w_is_fix ? BCD_ZERO  : w_a_dig;
  assign w_cell_b  = w_is_fix ? w_res_dig : w_b_dig;
  assign w_cell_m  = w_is_fix ? 1'b1      : r_m;

  add_sub u_add_sub (
    .a    (w_cell_a),
    .b    (w_cell_b),
    .cin  (r_carry),
    .m    (w_cell_m),
    .f    (w_f),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_m        <= 1'b0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_result   <= '0;
      r_sign     <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_m        <= op_m;
            r_idx      <= '0;
            // A subtract starts with CIN=1 to turn 9's into 10's complement.
            r_carry    <= op_m;
            r_sign     <= 1'b0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= CALC;
          end
        end

        CALC: begin
          r_result[r_idx*DIGIT_W +: DIGIT_W] <= w_f;
          r_carry <= w_cout;
          if (r_idx == c_last_idx) begin
            if (!r_m) begin
              r_overflow <= w_cout;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end else if (w_cout) begin
              // Carry out of a 10's complement subtract means A >= B.
              r_sign  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_sign  <= 1'b1;
              r_idx   <= '0;
              r_carry <= 1'b1;
              r_state <= FIX;
            end
          end else begin
            r_idx <= r_idx + c_idx_one;
          end
        end

        FIX: begin
          r_result[r_idx*DIGIT_W +: DIGIT_W] <= w_f;
          r_carry <= w_cout;
          if (r_idx == c_last_idx) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + c_idx_one;
          end
        end

        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign sign     = r_sign;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bcd_serial_addsub                                      |
// | Purpose  : Self-checking bench for bcd_serial_addsub (NDIG=4).       |
// |            Expected results come from a decimal integer model and    |
// |            are queued at launch, then popped when done pulses.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_bcd_serial_addsub;

  localparam int NDIG = 4;
  localparam int W    = NDIG * 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op_m;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         sign;
  logic         overflow;

  bcd_serial_addsub #(.NDIG(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_m     (op_m),
    .a_in     (a_in),
    .b_in     (b_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .sign     (sign),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         sgn;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest launch.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result",   32'(result),   32'(mon_e.res));
        check("sign",     32'(sign),     32'(mon_e.sgn));
        check("overflow", 32'(overflow), 32'(mon_e.ovf));
        check("done_cyc", 32'(cyc),      32'(mon_e.cyc));
      end
    end
  end

  // Called at a negedge; leaves start high for exactly one rising edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t e;
    int   ai = bcd2int(a);
    int   bi = bcd2int(b);
    int   n  = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ready), 32'd1);
    if (!m) begin
      e.res = int2bcd((ai + bi) % 10000);
      e.sgn = 1'b0;
      e.ovf = (ai + bi) >= 10000;
      e.cyc = cyc + NDIG + 1;
    end else if (ai >= bi) begin
      e.res = int2bcd(ai - bi);
      e.sgn = 1'b0;
      e.ovf = 1'b0;
      e.cyc = cyc + NDIG + 1;
    end else begin
      e.res = int2bcd(bi - ai);
      e.sgn = 1'b1;
      e.ovf = 1'b0;
      e.cyc = cyc + 2 * NDIG + 1;
    end
    sb.push_back(e);
    a_in  = a;
    b_in  = b;
    op_m  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    op_m  = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready",    32'(ready),    32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_result",   32'(result),   32'd0);
    check("rst_sign",     32'(sign),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    launch(16'h1234, 16'h5678, 1'b0); wait_idle();
    launch(16'h9999, 16'h0001, 1'b0); wait_idle();
    launch(16'h0000, 16'h0000, 1'b0); wait_idle();
    launch(16'h5000, 16'h1234, 1'b1); wait_idle();
    launch(16'h4321, 16'h4321, 1'b1); wait_idle();

    // Negative subtract: observe the raw 10's complement after CALC.
    launch(16'h0003, 16'h0005, 1'b1);
    repeat (4) @(negedge clk);
    check("calc_interm", 32'(result), 32'h9998);
    check("fix_busy",    32'(busy),   32'd1);
    wait_idle();

    // start held high with junk operands for the whole operation.
    d0 = done_cnt;
    launch(16'h0003, 16'h0005, 1'b1);
    start = 1'b1;
    for (int i = 2; i <= 2 * NDIG + 1; i++) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
      op_m = 1'($urandom);
      check("ready_low", 32'(ready), 32'd0);
      @(negedge clk);
    end
    check("ready_in_done", 32'(ready), 32'd0);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    check("one_done", 32'(done_cnt - d0), 32'd1);
    launch(16'h1234, 16'h5678, 1'b0); wait_idle();

    // Reset during the third CALC cycle discards the operation.
    d0 = done_cnt;
    @(negedge clk);
    a_in  = 16'h1234;
    b_in  = 16'h5678;
    op_m  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready",    32'(ready),    32'd1);
    check("mid_rst_busy",     32'(busy),     32'd0);
    check("mid_rst_done",     32'(done),     32'd0);
    check("mid_rst_result",   32'(result),   32'd0);
    check("mid_rst_sign",     32'(sign),     32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    repeat (6) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    launch(16'h1234, 16'h5678, 1'b0); wait_idle();

    for (int k = 0; k < 6; k++) begin
      launch(int2bcd(int'($urandom_range(0, 9999))), int2bcd(int'($urandom_range(0, 9999))),
             1'($urandom_range(0, 1)));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
